// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access unit: access sizes, FSM states and a byte-count helper.
package mem_access_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned STRBW = XLEN / 8;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'b00,
    MEM_SIZE_HALF = 2'b01,
    MEM_SIZE_WORD = 2'b10
  } mem_access_size_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } mem_acc_state_t;

  // Unused size encoding behaves as a full word.
  function automatic logic [2:0] mem_size_bytes(input mem_access_size_t size);
    case (size)
      MEM_SIZE_BYTE: return 3'd1;
      MEM_SIZE_HALF: return 3'd2;
      default:       return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane math: strobe mask, shifted store data and right-aligned masked load data.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]       i_offset,
  input  mem_access_size_t i_size,
  input  logic [XLEN-1:0]  i_wdata,
  input  logic [2*XLEN-1:0] i_rdata64,
  output logic [2*STRBW-1:0] o_m8,
  output logic [2*XLEN-1:0] o_w64,
  output logic [XLEN-1:0]  o_rdata
);

  logic [2:0]      w_nbytes;
  logic [7:0]      w_base;
  logic [4:0]      w_shift;
  logic [XLEN-1:0] w_rmask;

  assign w_nbytes = mem_size_bytes(i_size);
  assign w_base   = (8'd1 << w_nbytes) - 8'd1;
  assign w_shift  = {i_offset, 3'b000};

  assign o_m8  = w_base << i_offset;
  assign o_w64 = {{XLEN{1'b0}}, i_wdata} << w_shift;

  // A full word needs no mask; shorter sizes keep only their low bytes.
  assign w_rmask = (w_nbytes == 3'd4) ? {XLEN{1'b1}}
                                      : ((32'd1 << {w_nbytes, 3'b000}) - 32'd1);
  assign o_rdata = 32'(i_rdata64 >> w_shift) & w_rmask;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns one core request into one or two word-aligned bus beats.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [XLEN-1:0]  req_addr_i,
  input  mem_access_size_t req_size_i,
  input  logic [XLEN-1:0]  req_wdata_i,
  output logic             resp_valid_o,
  output logic [XLEN-1:0]  resp_rdata_o,
  output logic             bus_valid_o,
  input  logic             bus_ready_i,
  output logic             bus_we_o,
  output logic [XLEN-1:0]  bus_addr_o,
  output logic [STRBW-1:0] bus_wstrb_o,
  output logic [XLEN-1:0]  bus_wdata_o,
  input  logic             bus_rvalid_i,
  input  logic [XLEN-1:0]  bus_rdata_i
);

  mem_acc_state_t   r_state;
  logic             r_we;
  logic [1:0]       r_offset;
  mem_access_size_t r_size;
  logic [XLEN-1:0]  r_wdata;
  logic [XLEN-1:0]  r_lo;

  logic [1:0]         w_offset;
  mem_access_size_t   w_size;
  logic [XLEN-1:0]    w_wdata;
  logic [2*XLEN-1:0]  w_rdata64;
  logic [2*STRBW-1:0] w_m8;
  logic [2*XLEN-1:0]  w_w64;
  logic [XLEN-1:0]    w_rdata;
  logic               w_split;

  // In IDLE the aligner sees the incoming request so beat0 can register on acceptance.
  assign w_offset  = (r_state == ST_IDLE) ? req_addr_i[1:0] : r_offset;
  assign w_size    = (r_state == ST_IDLE) ? req_size_i      : r_size;
  assign w_wdata   = (r_state == ST_IDLE) ? req_wdata_i     : r_wdata;
  assign w_rdata64 = (r_state == ST_WAIT1) ? {bus_rdata_i, r_lo} : {{XLEN{1'b0}}, bus_rdata_i};
  assign w_split   = |w_m8[2*STRBW-1:STRBW];

  assign req_ready_o = (r_state == ST_IDLE);

  mem_lane_align u_align (
    .i_offset  (w_offset),
    .i_size    (w_size),
    .i_wdata   (w_wdata),
    .i_rdata64 (w_rdata64),
    .o_m8      (w_m8),
    .o_w64     (w_w64),
    .o_rdata   (w_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_offset     <= 2'b00;
      r_size       <= MEM_SIZE_BYTE;
      r_wdata      <= '0;
      r_lo         <= '0;
      bus_valid_o  <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_wstrb_o  <= '0;
      bus_wdata_o  <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
    end else begin
      resp_valid_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_we        <= req_we_i;
            r_offset    <= req_addr_i[1:0];
            r_size      <= req_size_i;
            r_wdata     <= req_wdata_i;
            bus_valid_o <= 1'b1;
            bus_we_o    <= req_we_i;
            bus_addr_o  <= {req_addr_i[XLEN-1:2], 2'b00};
            bus_wstrb_o <= w_m8[STRBW-1:0];
            bus_wdata_o <= w_w64[XLEN-1:0];
            r_state     <= ST_REQ0;
          end
        end
        ST_REQ0: begin
          if (bus_ready_i) begin
            bus_valid_o <= 1'b0;
            r_state     <= ST_WAIT0;
          end
        end
        ST_WAIT0: begin
          if (bus_rvalid_i) begin
            r_lo <= bus_rdata_i;
            if (w_split) begin
              // Second beat covers the next word; the address wraps at the top of memory.
              bus_valid_o <= 1'b1;
              bus_addr_o  <= bus_addr_o + 32'd4;
              bus_wstrb_o <= w_m8[2*STRBW-1:STRBW];
              bus_wdata_o <= w_w64[2*XLEN-1:XLEN];
              r_state     <= ST_REQ1;
            end else begin
              resp_valid_o <= 1'b1;
              resp_rdata_o <= r_we ? '0 : w_rdata;
              r_state      <= ST_RESP;
            end
          end
        end
        ST_REQ1: begin
          if (bus_ready_i) begin
            bus_valid_o <= 1'b0;
            r_state     <= ST_WAIT1;
          end
        end
        ST_WAIT1: begin
          if (bus_rvalid_i) begin
            resp_valid_o <= 1'b1;
            resp_rdata_o <= r_we ? '0 : w_rdata;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized traffic vs a byte-level memory model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_we_i;
  logic [31:0]      req_addr_i;
  mem_access_size_t req_size_i;
  logic [31:0]      req_wdata_i;
  logic             resp_valid_o;
  logic [31:0]      resp_rdata_o;
  logic             bus_valid_o;
  logic             bus_ready_i;
  logic             bus_we_o;
  logic [31:0]      bus_addr_o;
  logic [3:0]       bus_wstrb_o;
  logic [31:0]      bus_wdata_o;
  logic             bus_rvalid_i;
  logic [31:0]      bus_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_access_unit dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_size_i   (req_size_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .bus_valid_o  (bus_valid_o),
    .bus_ready_i  (bus_ready_i),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wstrb_o  (bus_wstrb_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  int checks = 0;
  int failures = 0;

  // bus_mem is what the DUT's beats touch; ref_mem is the model's view of memory.
  logic [7:0] bus_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  logic [31:0] beat_addr  [4];
  logic [3:0]  beat_strb  [4];
  logic        beat_we    [4];
  logic [31:0] beat_wdata [4];
  int          nbeats;
  int          resp_cyc;
  logic [31:0] resp_data;
  int          stab_err;
  int          rdy_err;
  int          pulse_err;

  function automatic logic [7:0] fill_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : fill_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill_byte(a);
  endfunction

  task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      bus_mem[a + 32'(i)] = w[8*i +: 8];
      ref_mem[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and act as the bus slave until the response pulse.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                         input logic [31:0] wd, input int rdy_lat, input int rv_lat);
    int cyc;
    int hold;
    int rv_wait;
    bit outstanding;
    bit done;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_strb;
    logic        s_we;
    cyc = 0; hold = 0; rv_wait = 0; outstanding = 0; done = 0;
    s_addr = '0; s_wdata = '0; s_strb = '0; s_we = 1'b0;
    nbeats = 0; stab_err = 0; rdy_err = 0; pulse_err = 0; resp_cyc = -1; resp_data = '0;
    @(negedge clk_i);
    if (req_ready_o !== 1'b1) rdy_err++;
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
    req_size_i = mem_access_size_t'(sz); req_wdata_i = wd;
    @(negedge clk_i);
    req_valid_i = 1'b0; req_we_i = ~we; req_addr_i = $urandom; req_wdata_i = $urandom;
    cyc = 1;
    while (!done && cyc < 100) begin
      bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
      if (resp_valid_o === 1'b1) begin
        resp_data = resp_rdata_o;
        resp_cyc  = cyc;
        done      = 1;
      end else begin
        if (req_ready_o !== 1'b0) rdy_err++;
        if (outstanding) begin
          if (bus_valid_o !== 1'b0) stab_err++;
          if (rv_wait == 0) begin
            int bi;
            bi = nbeats - 1;
            bus_rvalid_i = 1'b1;
            outstanding  = 0;
            if (bi < 4) begin
              for (int i = 0; i < 4; i++) begin
                if (beat_we[bi]) begin
                  if (beat_strb[bi][i]) bus_mem[beat_addr[bi] + 32'(i)] = beat_wdata[bi][8*i +: 8];
                end else begin
                  bus_rdata_i[8*i +: 8] = bus_rd(beat_addr[bi] + 32'(i));
                end
              end
            end
          end else begin
            rv_wait--;
          end
        end else if (bus_valid_o === 1'b1) begin
          if (hold == 0) begin
            s_addr = bus_addr_o; s_wdata = bus_wdata_o; s_strb = bus_wstrb_o; s_we = bus_we_o;
          end else if (bus_addr_o !== s_addr || bus_wdata_o !== s_wdata ||
                       bus_wstrb_o !== s_strb || bus_we_o !== s_we) begin
            stab_err++;
          end
          if (hold >= rdy_lat) begin
            bus_ready_i = 1'b1;
            if (nbeats < 4) begin
              beat_addr[nbeats] = bus_addr_o; beat_strb[nbeats] = bus_wstrb_o;
              beat_we[nbeats] = bus_we_o;     beat_wdata[nbeats] = bus_wdata_o;
            end
            nbeats++;
            outstanding = 1;
            rv_wait = rv_lat;
            hold = 0;
          end else begin
            hold++;
          end
        end
        @(negedge clk_i);
        cyc++;
      end
    end
    if (done) begin
      @(negedge clk_i);
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) pulse_err++;
    end
  endtask

  // Derive expected beats/result from the byte addresses the access covers, then compare.
  task automatic check_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [1:0] sz, input logic [31:0] wd,
                           input int rdy_lat, input int rv_lat);
    int n;
    int en;
    logic [31:0] ea [2];
    logic [3:0]  es [2];
    logic [31:0] ew [2];
    logic [31:0] er;
    logic [31:0] a;
    int b;
    int lane;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ea[0] = addr & 32'hFFFF_FFFC;
    ea[1] = ea[0] + 32'd4;
    es[0] = '0; es[1] = '0; ew[0] = '0; ew[1] = '0; er = '0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      b = ((a & 32'hFFFF_FFFC) == ea[0]) ? 0 : 1;
      lane = int'(a[1:0]);
      es[b][lane] = 1'b1;
      ew[b][8*lane +: 8] = wd[8*k +: 8];
      er[8*k +: 8] = ref_rd(a);
    end
    en = (es[1] != 4'b0) ? 2 : 1;
    chk({tag, ".resp_seen"}, 32'(resp_cyc >= 0), 32'd1);
    chk({tag, ".nbeats"}, 32'(nbeats), 32'(en));
    for (int i = 0; i < en && i < nbeats && i < 4; i++) begin
      chk($sformatf("%s.addr%0d", tag, i), beat_addr[i], ea[i]);
      chk($sformatf("%s.strb%0d", tag, i), 32'(beat_strb[i]), 32'(es[i]));
      chk($sformatf("%s.we%0d", tag, i), 32'(beat_we[i]), 32'(we));
      if (we) begin
        logic [31:0] lm;
        lm = '0;
        for (int l = 0; l < 4; l++) if (es[i][l]) lm[8*l +: 8] = 8'hFF;
        chk($sformatf("%s.wdata%0d", tag, i), beat_wdata[i] & lm, ew[i]);
      end
    end
    chk({tag, ".rdata"}, resp_data, we ? 32'd0 : er);
    chk({tag, ".latency"}, 32'(resp_cyc), 32'(1 + en * (2 + rdy_lat + rv_lat)));
    chk({tag, ".stable"}, 32'(stab_err), 32'd0);
    chk({tag, ".req_ready"}, 32'(rdy_err), 32'd0);
    chk({tag, ".pulse"}, 32'(pulse_err), 32'd0);
    if (we) for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = wd[8*k +: 8];
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [1:0] sz, input logic [31:0] wd, input int rdy_lat, input int rv_lat);
    run_txn(we, addr, sz, wd, rdy_lat, rv_lat);
    check_txn(tag, we, addr, sz, wd, rdy_lat, rv_lat);
  endtask

  initial begin
    reset_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_size_i = MEM_SIZE_WORD; req_wdata_i = '0;
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst.bus_valid", 32'(bus_valid_o), 32'd0);
    chk("rst.bus_we", 32'(bus_we_o), 32'd0);
    chk("rst.bus_addr", bus_addr_o, 32'd0);
    chk("rst.bus_wstrb", 32'(bus_wstrb_o), 32'd0);
    chk("rst.bus_wdata", bus_wdata_o, 32'd0);
    chk("rst.resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst.resp_rdata", resp_rdata_o, 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst.req_ready", 32'(req_ready_o), 32'd1);

    // Aligned word load, zero-latency bus.
    preload_word(32'h100, 32'hDEAD_BEEF);
    txn("lw_aligned", 1'b0, 32'h100, 2'b10, 32'h0, 0, 0);
    chk("lw_aligned.value", resp_data, 32'hDEAD_BEEF);
    chk("lw_aligned.cycle", 32'(resp_cyc), 32'd3);

    txn("sb_203", 1'b1, 32'h203, 2'b00, 32'h0000_00A5, 0, 0);
    chk("sb_203.full_wdata", beat_wdata[0], 32'hA500_0000);

    preload_word(32'h104, 32'h1122_3344);
    preload_word(32'h108, 32'h5566_7788);
    txn("lw_106", 1'b0, 32'h106, 2'b10, 32'h0, 0, 0);
    chk("lw_106.value", resp_data, 32'h7788_1122);
    chk("lw_106.cycle", 32'(resp_cyc), 32'd5);

    txn("sh_wrap", 1'b1, 32'hFFFF_FFFF, 2'b01, 32'h0000_BEEF, 0, 0);
    chk("sh_wrap.full_wdata0", beat_wdata[0], 32'hEF00_0000);
    chk("sh_wrap.full_wdata1", beat_wdata[1], 32'h0000_00BE);
    txn("lh_wrap", 1'b0, 32'hFFFF_FFFF, 2'b01, 32'h0, 1, 1);
    chk("lh_wrap.value", resp_data, 32'h0000_BEEF);

    txn("backpressure", 1'b0, 32'h100, 2'b10, 32'h0, 3, 0);
    txn("size_unused", 1'b0, 32'h105, 2'b11, 32'h0, 0, 2);

    // Reset while a beat is outstanding, then a stray completion.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h104; req_size_i = MEM_SIZE_WORD;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("rstmid.bus_valid_pre", 32'(bus_valid_o), 32'd1);
    bus_ready_i = 1'b1;
    @(negedge clk_i);
    bus_ready_i = 1'b0;
    chk("rstmid.waiting", 32'(req_ready_o), 32'd0);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("rstmid.bus_valid", 32'(bus_valid_o), 32'd0);
    chk("rstmid.resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rstmid.req_ready", 32'(req_ready_o), 32'd1);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    chk("stray.resp_valid", 32'(resp_valid_o), 32'd0);
    chk("stray.bus_valid", 32'(bus_valid_o), 32'd0);
    @(negedge clk_i);
    chk("stray.resp_valid2", 32'(resp_valid_o), 32'd0);
    chk("stray.req_ready", 32'(req_ready_o), 32'd1);
    preload_word(32'h0, 32'h4433_9C11);
    txn("lbu_1", 1'b0, 32'h1, 2'b00, 32'h0, 0, 0);
    chk("lbu_1.value", resp_data, 32'h0000_009C);

    // Randomized mix of loads and stores around a window and the address wrap.
    for (int t = 0; t < 40; t++) begin
      logic        rwe;
      logic [31:0] raddr;
      logic [1:0]  rsz;
      rwe   = 1'($urandom_range(0, 1));
      raddr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                          : 32'h400 + 32'($urandom_range(0, 63));
      rsz   = 2'($urandom_range(0, 3));
      txn($sformatf("rand%0d", t), rwe, raddr, rsz, $urandom,
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sits between the multicycle core datapath and the external 32-bit memory bus. Takes one byte, half or word load/store request per transaction and drives a word-aligned valid/ready bus with byte strobes. Misaligned accesses that cross a word boundary are split into two bus beats. Load data is returned right-aligned and zero-extended. The control FSM holds its DEMW state until the response arrives; sign extension stays in the regfile input mux.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  core request present.
- req_ready_o  out  1  unit can accept a request; high only in IDLE.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address; any alignment.
- req_size_i  in  mem_access_size_t  BYTE/HALF/WORD; the unused encoding is treated as WORD.
- req_wdata_i  in  32  store data, right-aligned.
- resp_valid_o  out  1  one-cycle pulse: transaction complete.
- resp_rdata_o  out  32  load result, right-aligned, zero-extended; 0 for stores.
- bus_valid_o  out  1  bus beat request.
- bus_ready_i  in  1  bus accepts the beat.
- bus_we_o  out  1  beat is a write.
- bus_addr_o  out  32  word address; bits [1:0] always 0.
- bus_wstrb_o  out  4  byte-lane enables, used for both reads and writes.
- bus_wdata_o  out  32  lane-shifted write data.
- bus_rvalid_i  in  1  beat completion; read data is valid, or the write is acknowledged.
- bus_rdata_i  in  32  read word.

## Operation
- **States:** IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- **IDLE:** a request is accepted when req_valid_i && req_ready_o. Latch we, addr, size and wdata. Go to REQ0.
- **Lane math:**
  - o = addr[1:0]; n = 1, 2 or 4 bytes.
  - m8 = ((1<<n)-1) << o, an 8-bit mask.
  - w64 = {32'b0, wdata} << 8*o.
  - Beat0: address = {addr[31:2], 2'b00}, wstrb = m8[3:0], wdata = w64[31:0].
  - Split = (m8[7:4] != 0). Beat1: address = beat0 address + 4 (wraps 0xFFFFFFFC→0), wstrb = m8[7:4], wdata = w64[63:32].
- **REQ0/REQ1:** bus_valid_o = 1 with the beat's fields held stable until bus_ready_i. On acceptance go to WAIT0/WAIT1.
- **WAIT0:** on bus_rvalid_i, capture bus_rdata_i as lo, then go to REQ1 if split, else to RESP.
- **WAIT1:** on bus_rvalid_i, capture hi and go to RESP.
- **RESP:**
  - resp_valid_o = 1.
  - For loads, resp_rdata_o = ({hi, lo} >> 8*o) masked to n bytes; hi = 0 when not split.
  - Next state is IDLE.
- **bus_rvalid_i outside WAIT states:** ignored.
- **Reset at any point:** state goes to IDLE, all registered outputs clear, and any in-flight beat is abandoned. A late bus_rvalid_i is then ignored.

## Timing
- **Reset values:** bus_valid_o=0, bus_we_o=0, bus_addr_o=0, bus_wstrb_o=0, bus_wdata_o=0, resp_valid_o=0, resp_rdata_o=0.
- **req_ready_o:** equals (state==IDLE), so it is 1 in the first cycle after reset deasserts.
- **Registered bus and response outputs:** bus_valid_o goes high the cycle after request acceptance.
- **Minimum latency, aligned access with ready and rvalid immediate:**
  - Accept at cycle 0.
  - bus_valid_o at cycle 1.
  - rvalid at cycle 2.
  - resp_valid_o at cycle 3.
  - Next accept at cycle 4.
- **Split accesses:** two extra cycles minimum; resp_valid_o at cycle 5.
- **Bus rules:**
  - At most one outstanding beat.
  - bus_rvalid_i arrives no earlier than the cycle after the beat is accepted.
  - No beat is issued with wstrb = 0.

## Structure
- **definitions package additions:**
  - mem_acc_state_t, a 3-bit enum of the six states.
  - A helper function returning the byte count for a mem_access_size_t.
- **mem_access_size_t:** reused unchanged.
- **Sub-module mem_lane_align:** combinational; computes m8, w64 and the read extract/mask from (o, size, wdata, {hi, lo}). It is instantiated once.
- **Top module:** holds the FSM and registers only.

## Test plan
- **Aligned LW:** addr 0x100; bus returns 0xDEADBEEF immediately → one beat at 0x100 with wstrb 1111; resp_rdata 0xDEADBEEF at cycle 3.
- **SB at 0x203, data 0x000000A5:** one beat at 0x200, wstrb 1000, wdata 0xA5000000, we=1; resp_rdata 0.
- **Misaligned LW at 0x106:**
  - Beat0 at 0x104, wstrb 1100, returns 0x1122_3344.
  - Beat1 at 0x108, wstrb 0011, returns 0x5566_7788.
  - resp_rdata 0x7788_1122.
- **SH at 0xFFFFFFFF, data 0xBEEF:**
  - Beat0 at 0xFFFFFFFC, wstrb 1000, wdata 0xEF000000.
  - Beat1 at 0x00000000, wstrb 0001, wdata 0x000000BE.
- **Backpressure:** hold bus_ready_i low for 3 cycles → bus_valid_o, address, strobe and data held stable, and req_ready_o stays 0 throughout.
- **Reset and stray response:** assert reset in WAIT0, then pulse bus_rvalid_i in IDLE → bus_valid_o=0 and resp_valid_o=0 after the edge; no resp_valid_o for the stray rvalid; the next LBU at 0x1 returns the lane-1 byte zero-extended.
